// File: rtl/usb_rx_pkg.sv
// Shared constants for the USB RX packet assembler: RxCtrl tags, PID type codes,
// FSM state encoding and result flag bit positions.
package usb_rx_pkg;

    localparam logic [7:0] RXCTRL_PID    = 8'd0;
    localparam logic [7:0] RXCTRL_DATA   = 8'd1;
    localparam logic [7:0] RXCTRL_STATUS = 8'd2;

    localparam logic [1:0] PIDT_SPECIAL = 2'b00;
    localparam logic [1:0] PIDT_TOKEN   = 2'b01;
    localparam logic [1:0] PIDT_HSHK    = 2'b10;
    localparam logic [1:0] PIDT_DATA    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_HSHK,
        ST_DATA,
        ST_DONE
    } rx_state_e;

    localparam int FLAG_ABORT    = 0;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_RUNT     = 2;

    function automatic rx_state_e pid_to_state(input logic [1:0] pid_type);
        case (pid_type)
            PIDT_TOKEN: return ST_TOKEN;
            PIDT_HSHK:  return ST_HSHK;
            PIDT_DATA:  return ST_DATA;
            default:    return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rx_crc_strip_pipe.sv
// Two-deep byte hold: a push into a full hold releases the oldest byte on emit/dout
// in the same cycle, so the last two bytes of a packet (the CRC16) are never released.
module rx_crc_strip_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       flush,
    input  logic [7:0] din,
    output logic       emit,
    output logic [7:0] dout,
    output logic [1:0] level
);

    logic [7:0] b0_q, b0_d;
    logic [7:0] b1_q, b1_d;
    logic [1:0] lvl_q, lvl_d;

    always_comb begin
        b0_d  = b0_q;
        b1_d  = b1_q;
        lvl_d = lvl_q;
        emit  = 1'b0;
        dout  = b0_q;
        if (flush) begin
            lvl_d = 2'd0;
        end else if (push) begin
            case (lvl_q)
                2'd0: begin
                    b0_d  = din;
                    lvl_d = 2'd1;
                end
                2'd1: begin
                    b1_d  = din;
                    lvl_d = 2'd2;
                end
                default: begin
                    emit = 1'b1;
                    b0_d = b1_q;
                    b1_d = din;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b0_q  <= 8'h00;
            b1_q  <= 8'h00;
            lvl_q <= 2'd0;
        end else begin
            b0_q  <= b0_d;
            b1_q  <= b1_d;
            lvl_q <= lvl_d;
        end
    end

    assign level = lvl_q;

endmodule

// File: rtl/rx_packet_assembler.sv
// Frames the tagged RX byte stream into packets and publishes one result per packet.
// USB_RX_CRC_STRIP_EN: when defined, the trailing CRC16 is held back and dropped.
module rx_packet_assembler
    import usb_rx_pkg::*;
#(
    parameter int MAX_PKT_BYTES = 1023,
    parameter int CNT_W         = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       RxDataIn,
    input  logic [7:0]       RxCtrlIn,
    input  logic             RxDataInWEn,
    input  logic             fifoFull,
    output logic             fifoWEn,
    output logic [7:0]       fifoData,
    output logic             pktDone,
    output logic [3:0]       pktPID,
    output logic [7:0]       pktStatus,
    output logic [CNT_W-1:0] pktByteCnt,
    output logic [2:0]       pktFlags,
    output logic [15:0]      tokenData
);

    rx_state_e        state_q, state_d;
    logic [3:0]       pid_q, pid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       tok_n_q, tok_n_d;
    logic [15:0]      tok_q, tok_d;
    logic             fifo_wen_q, fifo_wen_d;
    logic [7:0]       fifo_data_q, fifo_data_d;
    // Closed-packet result waits here one clock before it is published.
    logic             pend_q, pend_d;
    logic [3:0]       res_pid_q, res_pid_d;
    logic [7:0]       res_status_q, res_status_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic [2:0]       res_flags_q, res_flags_d;
    logic             pkt_done_q, pkt_done_d;
    logic [3:0]       pkt_pid_q, pkt_pid_d;
    logic [7:0]       pkt_status_q, pkt_status_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [2:0]       pkt_flags_q, pkt_flags_d;

    logic       in_pkt;
    logic       data_push;
    logic       pipe_flush;
    logic       emit;
    logic [7:0] emit_byte;
    logic       runt_now;

    assign in_pkt     = (state_q == ST_TOKEN) || (state_q == ST_HSHK) || (state_q == ST_DATA);
    assign data_push  = RxDataInWEn && (RxCtrlIn == RXCTRL_DATA) && (state_q == ST_DATA);
    assign pipe_flush = RxDataInWEn && ((RxCtrlIn == RXCTRL_PID) ||
                        ((RxCtrlIn == RXCTRL_STATUS) && (state_q == ST_DATA)));

`ifdef USB_RX_CRC_STRIP_EN
    logic [1:0] pipe_level;

    rx_crc_strip_pipe u_pipe (
        .clk   (clk),
        .rst   (rst),
        .push  (data_push),
        .flush (pipe_flush),
        .din   (RxDataIn),
        .emit  (emit),
        .dout  (emit_byte),
        .level (pipe_level)
    );

    assign runt_now = (state_q == ST_DATA) && (pipe_level < 2'd2);
`else
    assign emit      = data_push;
    assign emit_byte = RxDataIn;
    assign runt_now  = 1'b0;
`endif

    always_comb begin
        state_d      = (state_q == ST_DONE) ? ST_IDLE : state_q;
        pid_d        = pid_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        tok_n_d      = tok_n_q;
        tok_d        = tok_q;
        fifo_wen_d   = 1'b0;
        fifo_data_d  = fifo_data_q;
        pend_d       = 1'b0;
        res_pid_d    = res_pid_q;
        res_status_d = res_status_q;
        res_cnt_d    = res_cnt_q;
        res_flags_d  = res_flags_q;
        pkt_done_d   = 1'b0;
        pkt_pid_d    = pkt_pid_q;
        pkt_status_d = pkt_status_q;
        pkt_cnt_d    = pkt_cnt_q;
        pkt_flags_d  = pkt_flags_q;

        if (pend_q) begin
            pkt_done_d   = 1'b1;
            pkt_pid_d    = res_pid_q;
            pkt_status_d = res_status_q;
            pkt_cnt_d    = res_cnt_q;
            pkt_flags_d  = res_flags_q;
        end

        if (emit) begin
            if (fifoFull || (cnt_q == CNT_W'(MAX_PKT_BYTES))) begin
                ovf_d = 1'b1;
            end else begin
                fifo_wen_d  = 1'b1;
                fifo_data_d = emit_byte;
                cnt_d       = cnt_q + 1'b1;
            end
        end

        if (RxDataInWEn) begin
            case (RxCtrlIn)
                RXCTRL_PID: begin
                    if (in_pkt) begin
                        pend_d                   = 1'b1;
                        res_pid_d                = pid_q;
                        res_status_d             = 8'h00;
                        res_cnt_d                = cnt_q;
                        res_flags_d              = 3'b000;
                        res_flags_d[FLAG_OVERFLOW] = ovf_q;
                        res_flags_d[FLAG_ABORT]  = 1'b1;
                    end
                    pid_d   = RxDataIn[3:0];
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    tok_n_d = 2'd0;
                    state_d = pid_to_state(RxDataIn[1:0]);
                end
                RXCTRL_DATA: begin
                    if (state_q == ST_TOKEN) begin
                        if (tok_n_q == 2'd0) begin
                            tok_d[7:0] = RxDataIn;
                            tok_n_d    = 2'd1;
                        end else if (tok_n_q == 2'd1) begin
                            tok_d[15:8] = RxDataIn;
                            tok_n_d     = 2'd2;
                        end
                    end
                end
                RXCTRL_STATUS: begin
                    if (in_pkt) begin
                        pend_d                     = 1'b1;
                        res_pid_d                  = pid_q;
                        res_status_d               = RxDataIn;
                        res_cnt_d                  = cnt_q;
                        res_flags_d                = 3'b000;
                        res_flags_d[FLAG_RUNT]     = runt_now;
                        res_flags_d[FLAG_OVERFLOW] = ovf_q;
                        state_d                    = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pid_q        <= 4'h0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            tok_n_q      <= 2'd0;
            tok_q        <= 16'h0000;
            fifo_wen_q   <= 1'b0;
            fifo_data_q  <= 8'h00;
            pend_q       <= 1'b0;
            res_pid_q    <= 4'h0;
            res_status_q <= 8'h00;
            res_cnt_q    <= '0;
            res_flags_q  <= 3'b000;
            pkt_done_q   <= 1'b0;
            pkt_pid_q    <= 4'h0;
            pkt_status_q <= 8'h00;
            pkt_cnt_q    <= '0;
            pkt_flags_q  <= 3'b000;
        end else begin
            state_q      <= state_d;
            pid_q        <= pid_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            tok_n_q      <= tok_n_d;
            tok_q        <= tok_d;
            fifo_wen_q   <= fifo_wen_d;
            fifo_data_q  <= fifo_data_d;
            pend_q       <= pend_d;
            res_pid_q    <= res_pid_d;
            res_status_q <= res_status_d;
            res_cnt_q    <= res_cnt_d;
            res_flags_q  <= res_flags_d;
            pkt_done_q   <= pkt_done_d;
            pkt_pid_q    <= pkt_pid_d;
            pkt_status_q <= pkt_status_d;
            pkt_cnt_q    <= pkt_cnt_d;
            pkt_flags_q  <= pkt_flags_d;
        end
    end

    assign fifoWEn    = fifo_wen_q;
    assign fifoData   = fifo_data_q;
    assign pktDone    = pkt_done_q;
    assign pktPID     = pkt_pid_q;
    assign pktStatus  = pkt_status_q;
    assign pktByteCnt = pkt_cnt_q;
    assign pktFlags   = pkt_flags_q;
    assign tokenData  = tok_q;

endmodule

// File: tb/tb_rx_packet_assembler.sv
// Bench for rx_packet_assembler: directed vector table, hand-written corner sequences
// and random traffic checked against a queue-based packet model.
module tb_rx_packet_assembler;

    localparam int MAXB = 1023;
`ifdef USB_RX_CRC_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  RxDataIn = 8'h00;
    logic [7:0]  RxCtrlIn = 8'h00;
    logic        RxDataInWEn = 1'b0;
    logic        fifoFull = 1'b0;
    logic        fifoWEn;
    logic [7:0]  fifoData;
    logic        pktDone;
    logic [3:0]  pktPID;
    logic [7:0]  pktStatus;
    logic [9:0]  pktByteCnt;
    logic [2:0]  pktFlags;
    logic [15:0] tokenData;

    always #5 clk = ~clk;

    rx_packet_assembler #(.MAX_PKT_BYTES(MAXB), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .RxDataIn(RxDataIn), .RxCtrlIn(RxCtrlIn),
        .RxDataInWEn(RxDataInWEn), .fifoFull(fifoFull), .fifoWEn(fifoWEn),
        .fifoData(fifoData), .pktDone(pktDone), .pktPID(pktPID), .pktStatus(pktStatus),
        .pktByteCnt(pktByteCnt), .pktFlags(pktFlags), .tokenData(tokenData)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  pid;
        logic [7:0]  st;
        int          cnt;
        logic [2:0]  fl;
        bit          tok_chk;
        logic [15:0] tok;
    } res_t;

    res_t        exp_res[$];
    logic [7:0]  exp_fifo[$];
    int          m_mode = 0;   // 0 idle, 1 token, 2 handshake, 3 data
    logic [3:0]  m_pid = 4'h0;
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    int          m_rx = 0;
    int          m_tokn = 0;
    logic [15:0] m_tok = 16'h0;
    logic [7:0]  m_held[$];

    task automatic model_emit(input logic [7:0] b, input logic full);
        if (full || m_cnt == MAXB) m_ovf = 1'b1;
        else begin
            exp_fifo.push_back(b);
            m_cnt++;
        end
    endtask

    task automatic model_close(input logic [7:0] st, input bit abort);
        res_t r;
        r.pid = m_pid;
        r.st = st;
        r.cnt = m_cnt;
        r.fl = {STRIP && m_mode == 3 && m_rx < 2 && !abort, m_ovf, abort};
        r.tok_chk = (m_mode == 1) && !abort;
        r.tok = m_tok;
        exp_res.push_back(r);
    endtask

    task automatic model_step(input logic [7:0] c, input logic [7:0] d, input logic full);
        if (c == 8'd0) begin
            if (m_mode != 0) model_close(8'h00, 1'b1);
            m_pid = d[3:0]; m_cnt = 0; m_ovf = 1'b0; m_rx = 0; m_tokn = 0;
            m_held.delete();
            case (d[1:0])
                2'b01: m_mode = 1;
                2'b10: m_mode = 2;
                2'b11: m_mode = 3;
                default: m_mode = 0;
            endcase
        end else if (c == 8'd1) begin
            if (m_mode == 1) begin
                if (m_tokn == 0) m_tok[7:0] = d;
                else if (m_tokn == 1) m_tok[15:8] = d;
                m_tokn++;
            end else if (m_mode == 3) begin
                m_rx++;
                if (STRIP) begin
                    m_held.push_back(d);
                    if (m_held.size() > 2) model_emit(m_held.pop_front(), full);
                end else model_emit(d, full);
            end
        end else if (c == 8'd2) begin
            if (m_mode != 0) model_close(d, 1'b0);
            m_mode = 0;
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pid = 4'h0; m_cnt = 0; m_ovf = 1'b0; m_rx = 0; m_tokn = 0; m_tok = 16'h0;
        m_held.delete();
        exp_fifo.delete();
        exp_res.delete();
    endtask

    // ---------------- monitor ----------------
    int         n_wr = 0;
    int         n_done = 0;
    res_t       mon_r;
    logic [7:0] mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            if (fifoWEn) begin
                n_wr++;
                if (exp_fifo.size() == 0) begin
                    total++; bad++;
                    $display("FAIL fifo_extra: got write 0x%0h expected none at %0t", fifoData, $time);
                end else begin
                    mon_e = exp_fifo.pop_front();
                    chk("fifo_data", fifoData, mon_e);
                end
            end
            if (pktDone) begin
                n_done++;
                if (exp_res.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_extra: got pktDone expected none at %0t", $time);
                end else begin
                    mon_r = exp_res.pop_front();
                    chk("mdl_pid", pktPID, mon_r.pid);
                    chk("mdl_status", pktStatus, mon_r.st);
                    chk("mdl_cnt", pktByteCnt, mon_r.cnt);
                    chk("mdl_flags", pktFlags, mon_r.fl);
                    if (mon_r.tok_chk) chk("mdl_token", tokenData, mon_r.tok);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic strobe(input logic [7:0] c, input logic [7:0] d);
        model_step(c, d, fifoFull);
        RxCtrlIn = c; RxDataIn = d; RxDataInWEn = 1'b1;
        @(posedge clk); #1;
        RxDataInWEn = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int             n;
        logic [9:0][7:0] c;
        logic [9:0][7:0] d;
        logic [9:0]     full;
        logic [3:0]     e_pid;
        logic [7:0]     e_st;
        int             e_cnt;
        logic [2:0]     e_fl;
        logic [15:0]    e_tok;
    } vec_t;

    vec_t vt[4];

    task automatic add(input int v, input logic [7:0] c, input logic [7:0] d);
        vt[v].c[vt[v].n] = c;
        vt[v].d[vt[v].n] = d;
        vt[v].n++;
    endtask

    initial begin
        int w0, d0;
        logic [7:0] pn;
        for (int v = 0; v < 4; v++) begin vt[v].n = 0; vt[v].full = '0; end
        // 1: DATA0 with CRC
        add(0, 0, 8'hC3); add(0, 1, 8'h11); add(0, 1, 8'h22); add(0, 1, 8'h33); add(0, 1, 8'h44);
        add(0, 1, 8'hAA); add(0, 1, 8'hBB); add(0, 2, 8'h00);
        vt[0].e_pid = 4'h3; vt[0].e_st = 8'h00; vt[0].e_cnt = STRIP ? 4 : 6; vt[0].e_fl = 3'b000; vt[0].e_tok = 16'h0000;
        // 2: token
        add(1, 0, 8'h69); add(1, 1, 8'h05); add(1, 1, 8'h98); add(1, 2, 8'h00);
        vt[1].e_pid = 4'h9; vt[1].e_st = 8'h00; vt[1].e_cnt = 0; vt[1].e_fl = 3'b000; vt[1].e_tok = 16'h9805;
        // 3: DATA1 runt
        add(2, 0, 8'h4B); add(2, 1, 8'h5A); add(2, 2, 8'h01);
        vt[2].e_pid = 4'hB; vt[2].e_st = 8'h01; vt[2].e_cnt = STRIP ? 0 : 1;
        vt[2].e_fl = STRIP ? 3'b100 : 3'b000; vt[2].e_tok = 16'h9805;
        // 4: FIFO full on the second emit of a 6-byte payload
        add(3, 0, 8'hC3); add(3, 1, 8'h10); add(3, 1, 8'h20); add(3, 1, 8'h30); add(3, 1, 8'h40);
        add(3, 1, 8'h50); add(3, 1, 8'h60); add(3, 1, 8'h71); add(3, 1, 8'h72); add(3, 2, 8'h00);
        vt[3].full[STRIP ? 4 : 2] = 1'b1;
        vt[3].e_pid = 4'h3; vt[3].e_st = 8'h00; vt[3].e_cnt = STRIP ? 5 : 7; vt[3].e_fl = 3'b010; vt[3].e_tok = 16'h9805;

        // reset state
        #12;
        chk("rst_fifoWEn", fifoWEn, 0); chk("rst_fifoData", fifoData, 0);
        chk("rst_pktDone", pktDone, 0); chk("rst_pktPID", pktPID, 0);
        chk("rst_pktStatus", pktStatus, 0); chk("rst_pktByteCnt", pktByteCnt, 0);
        chk("rst_pktFlags", pktFlags, 0); chk("rst_tokenData", tokenData, 0);
        @(negedge clk); rst = 1'b0;
        idle(2);

        for (int v = 0; v < 4; v++) begin
            w0 = n_wr; d0 = n_done;
            for (int j = 0; j < vt[v].n; j++) begin
                fifoFull = vt[v].full[j];
                strobe(vt[v].c[j], vt[v].d[j]);
            end
            fifoFull = 1'b0;
            chk($sformatf("v%0d_done_early", v), pktDone, 0);
            idle(1);
            chk($sformatf("v%0d_done", v), pktDone, 1);
            chk($sformatf("v%0d_pid", v), pktPID, vt[v].e_pid);
            chk($sformatf("v%0d_status", v), pktStatus, vt[v].e_st);
            chk($sformatf("v%0d_cnt", v), pktByteCnt, vt[v].e_cnt);
            chk($sformatf("v%0d_flags", v), pktFlags, vt[v].e_fl);
            chk($sformatf("v%0d_token", v), tokenData, vt[v].e_tok);
            idle(3);
            chk($sformatf("v%0d_writes", v), n_wr - w0, vt[v].e_cnt);
            chk($sformatf("v%0d_ndone", v), n_done - d0, 1);
            chk($sformatf("v%0d_held", v), pktByteCnt, vt[v].e_cnt);
        end

        // DATA aborted by ACK, with write latency and pktDone timing
        strobe(0, 8'hC3);
        strobe(1, 8'h01);
        chk("lat_b1", fifoWEn, STRIP ? 0 : 1);
        strobe(1, 8'h02);
        chk("lat_b2", fifoWEn, STRIP ? 0 : 1);
        strobe(1, 8'h03);
        chk("lat_b3_wen", fifoWEn, 1);
        chk("lat_b3_data", fifoData, STRIP ? 8'h01 : 8'h03);
        strobe(0, 8'hD2);
        chk("abort_done_early", pktDone, 0);
        strobe(2, 8'h00);
        chk("abort_done", pktDone, 1);
        chk("abort_flags", pktFlags, 3'b001);
        chk("abort_cnt", pktByteCnt, STRIP ? 1 : 3);
        chk("abort_pid", pktPID, 4'h3);
        chk("abort_status", pktStatus, 8'h00);
        idle(1);
        chk("ack_done", pktDone, 1);
        chk("ack_pid", pktPID, 4'h2);
        chk("ack_flags", pktFlags, 3'b000);
        chk("ack_cnt", pktByteCnt, 0);
        idle(1);
        chk("ack_pulse", pktDone, 0);
        idle(2);

        // counter saturation at MAX_PKT_BYTES
        strobe(0, 8'hC3);
        for (int i = 0; i < MAXB + 3; i++) strobe(1, 8'(i));
        strobe(2, 8'h00);
        idle(4);
        chk("max_cnt", pktByteCnt, MAXB);
        chk("max_flags", pktFlags, 3'b010);

        // reset mid-packet, then a clean packet
        strobe(0, 8'hC3);
        strobe(1, 8'hE1); strobe(1, 8'hE2); strobe(1, 8'hE3);
        rst = 1'b1;
        model_reset();
        #3;
        chk("midrst_cnt", pktByteCnt, 0);
        chk("midrst_wen", fifoWEn, 0);
        @(negedge clk); rst = 1'b0;
        idle(2);
        d0 = n_done; w0 = n_wr;
        for (int j = 0; j < vt[0].n; j++) strobe(vt[0].c[j], vt[0].d[j]);
        idle(4);
        chk("postrst_ndone", n_done - d0, 1);
        chk("postrst_writes", n_wr - w0, vt[0].e_cnt);
        chk("postrst_cnt", pktByteCnt, vt[0].e_cnt);

        // random traffic against the model
        for (int p = 0; p < 200; p++) begin
            pn = {4'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            pn[7:4] = ~pn[3:0];
            if ($urandom_range(0, 7) == 0) strobe(1, 8'($urandom));
            strobe(0, pn);
            for (int j = $urandom_range(0, 8); j > 0; j--) begin
                fifoFull = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 9) == 0) strobe(8'($urandom_range(3, 255)), 8'($urandom));
                if ($urandom_range(0, 9) == 0) idle(1);
                strobe(1, 8'($urandom));
            end
            fifoFull = 1'b0;
            if ($urandom_range(0, 7) != 0) strobe(2, 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        strobe(2, 8'h00);
        idle(6);
        chk("end_fifo_q", exp_fifo.size(), 0);
        chk("end_res_q", exp_res.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
